// File: rtl/audio_pkg.sv
// Shared audio constants: system clock rate, musical note frequencies, the
// matching divisor values for note_clk_divider, and the upstream note codes.
package audio_pkg;

    localparam int unsigned DIVISOR_WIDTH = 32;
    localparam int unsigned SYS_CLK_HZ    = 50_000_000;

    localparam int unsigned FREQ_DO1 = 523;
    localparam int unsigned FREQ_RE  = 587;
    localparam int unsigned FREQ_MI  = 659;
    localparam int unsigned FREQ_FA  = 698;
    localparam int unsigned FREQ_SOL = 783;
    localparam int unsigned FREQ_LA  = 880;
    localparam int unsigned FREQ_SI  = 987;
    localparam int unsigned FREQ_DO2 = 1046;

    // Integer division truncates, e.g. DO1 -> 95602 system cycles per period.
    localparam int unsigned DIV_DO1 = SYS_CLK_HZ / FREQ_DO1;
    localparam int unsigned DIV_RE  = SYS_CLK_HZ / FREQ_RE;
    localparam int unsigned DIV_MI  = SYS_CLK_HZ / FREQ_MI;
    localparam int unsigned DIV_FA  = SYS_CLK_HZ / FREQ_FA;
    localparam int unsigned DIV_SOL = SYS_CLK_HZ / FREQ_SOL;
    localparam int unsigned DIV_LA  = SYS_CLK_HZ / FREQ_LA;
    localparam int unsigned DIV_SI  = SYS_CLK_HZ / FREQ_SI;
    localparam int unsigned DIV_DO2 = SYS_CLK_HZ / FREQ_DO2;

    localparam int unsigned NO_SOUND = 0;

    localparam logic [3:0] CODE_DO1 = 4'b0001;
    localparam logic [3:0] CODE_RE  = 4'b0011;
    localparam logic [3:0] CODE_MI  = 4'b0101;
    localparam logic [3:0] CODE_FA  = 4'b1001;
    localparam logic [3:0] CODE_SOL = 4'b0111;
    localparam logic [3:0] CODE_LA  = 4'b1011;
    localparam logic [3:0] CODE_SI  = 4'b1101;
    localparam logic [3:0] CODE_DO2 = 4'b1111;

endpackage

// File: rtl/note_clk_divider.sv
// Programmable square-wave divider: output period is 2*(notes>>1) clk_in
// cycles with 50 % duty; notes of 0 or 1 hold the output low (silence).
module note_clk_divider
    import audio_pkg::*;
#(
    parameter int WIDTH = DIVISOR_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] notes,
    output logic             clk_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] half_m1;
    logic [WIDTH-1:0] cnt;

    // notes is used live; a change is seen by the comparison on the next edge.
    assign half    = notes >> 1;
    assign half_m1 = half - ONE;

    // The >= lets a shrinking divisor toggle immediately instead of wrapping.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (half == '0) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt >= half_m1) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + ONE;
        end
    end

endmodule

// File: tb/tb_note_clk_divider.sv
// Bench for note_clk_divider: toggle spacing, silence, async reset, divisor
// shrink/grow and rapid note changes, checked against an expected queue.
module tb_note_clk_divider;
    import audio_pkg::*;

    localparam int W = 32;
    localparam int CLK_PERIOD = 10;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic [W-1:0]  notes  = '0;
    logic          clk_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    note_clk_divider #(.WIDTH(W)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .notes  (notes),
        .clk_out(clk_out)
    );

    always #(CLK_PERIOD/2) clk_in = ~clk_in;

    // Edges until clk_out changes; -1 if it does not change within limit.
    task automatic measure_gap(input int limit, output int gap);
        logic prev;
        bit   done;
        prev = clk_out;
        gap  = 0;
        done = 0;
        for (int k = 0; k < limit && !done; k++) begin
            @(posedge clk_in);
            #1;
            gap++;
            if (clk_out !== prev) done = 1;
        end
        if (!done) gap = -1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1;
        notes = DIV_DO1;
        repeat (3) @(posedge clk_in);
        #1;
        exp_q.push_back(0);
        e = exp_q.pop_front();
        checks++;
        if ({31'b0, clk_out} !== e) begin
            errors++;
            $display("FAIL reset_clk_out actual=%0b required=%0d", clk_out, e);
        end
        exp_q.push_back(0);
        e = exp_q.pop_front();
        checks++;
        if (dut.cnt !== e) begin
            errors++;
            $display("FAIL reset_cnt actual=%0d required=%0d", dut.cnt, e);
        end
    endtask

    task automatic test_period(input int n, input int gaps);
        int half, g, rise_prev, rise_last;
        logic [31:0] e;
        half = n >> 1;
        rise_prev = -1;
        rise_last = -1;
        reset = 1'b1;
        @(negedge clk_in);
        notes = n;
        @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < gaps; i++) exp_q.push_back(half);
        for (int i = 0; i < gaps; i++) begin
            measure_gap(half + 4, g);
            e = exp_q.pop_front();
            checks++;
            if (g !== int'(e)) begin
                errors++;
                $display("FAIL period_gap n=%0d idx=%0d actual=%0d required=%0d", n, i, g, e);
            end
            if (clk_out === 1'b1) begin
                rise_prev = rise_last;
                rise_last = int'($time);
            end
            if (i == 0) begin
                checks++;
                if (clk_out !== 1'b1) begin
                    errors++;
                    $display("FAIL first_toggle_rise n=%0d actual=%0b required=1", n, clk_out);
                end
            end
        end
        exp_q.push_back(2 * half * CLK_PERIOD);
        e = exp_q.pop_front();
        checks++;
        if (rise_last - rise_prev !== int'(e)) begin
            errors++;
            $display("FAIL period_time n=%0d actual=%0d required=%0d", n, rise_last - rise_prev, e);
        end
    endtask

    task automatic test_silence(input int quiet);
        int g;
        bit stayed;
        logic [31:0] e;
        reset = 1'b1;
        @(negedge clk_in);
        notes = 4;
        reset = 1'b0;
        measure_gap(8, g);
        @(negedge clk_in);
        notes = quiet;
        exp_q.push_back(0);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({31'b0, clk_out} !== e) begin
            errors++;
            $display("FAIL silence_low n=%0d actual=%0b required=%0d", quiet, clk_out, e);
        end
        stayed = 1;
        repeat (8) begin
            @(posedge clk_in);
            #1;
            if (clk_out !== 1'b0) stayed = 0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("FAIL silence_hold n=%0d actual=not_low required=low", quiet);
        end
        @(negedge clk_in);
        notes = 4;
        exp_q.push_back(2);
        measure_gap(8, g);
        e = exp_q.pop_front();
        checks++;
        if (g !== int'(e) || clk_out !== 1'b1) begin
            errors++;
            $display("FAIL silence_resume n=%0d actual_gap=%0d actual_out=%0b required_gap=%0d required_out=1",
                     quiet, g, clk_out, e);
        end
    endtask

    task automatic test_async_reset();
        int g;
        logic [31:0] e;
        reset = 1'b1;
        @(negedge clk_in);
        notes = 4;
        reset = 1'b0;
        measure_gap(8, g);
        checks++;
        if (clk_out !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_high actual=%0b required=1", clk_out);
        end
        @(posedge clk_in);
        #2;
        reset = 1'b1;
        exp_q.push_back(0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({31'b0, clk_out} !== e || dut.cnt !== 0) begin
            errors++;
            $display("FAIL async_reset actual_out=%0b actual_cnt=%0d required=%0d", clk_out, dut.cnt, e);
        end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        exp_q.push_back(2);
        measure_gap(8, g);
        e = exp_q.pop_front();
        checks++;
        if (g !== int'(e) || clk_out !== 1'b1) begin
            errors++;
            $display("FAIL async_restart actual_gap=%0d actual_out=%0b required_gap=%0d", g, clk_out, e);
        end
    endtask

    task automatic test_shrink();
        bit stayed;
        logic [31:0] e;
        reset = 1'b1;
        @(negedge clk_in);
        notes = DIV_DO1;
        reset = 1'b0;
        stayed = 1;
        repeat (43000) begin
            @(posedge clk_in);
            #1;
            if (clk_out !== 1'b0) stayed = 0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("FAIL shrink_do1_low actual=toggled required=low");
        end
        exp_q.push_back(43000);
        e = exp_q.pop_front();
        checks++;
        if (dut.cnt !== e) begin
            errors++;
            $display("FAIL shrink_cnt actual=%0d required=%0d", dut.cnt, e);
        end
        @(negedge clk_in);
        notes = DIV_RE;
        exp_q.push_back(1);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({31'b0, clk_out} !== e || dut.cnt !== 0) begin
            errors++;
            $display("FAIL shrink_toggle actual_out=%0b actual_cnt=%0d required_out=%0d", clk_out, dut.cnt, e);
        end
    endtask

    task automatic test_grow();
        int g;
        logic [31:0] e;
        reset = 1'b1;
        @(negedge clk_in);
        notes = 8;
        reset = 1'b0;
        measure_gap(10, g);
        @(negedge clk_in);
        notes = 20;
        exp_q.push_back(10);
        exp_q.push_back(10);
        for (int i = 0; i < 2; i++) begin
            measure_gap(20, g);
            e = exp_q.pop_front();
            checks++;
            if (g !== int'(e)) begin
                errors++;
                $display("FAIL grow_gap idx=%0d actual=%0d required=%0d", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq[5];
        logic [31:0] e;
        seq = '{DIV_DO1, DIV_RE, DIV_MI, DIV_FA, DIV_LA};
        @(negedge clk_in);
        notes = DIV_DO1;
        repeat (2000) @(posedge clk_in);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            notes = seq[i];
            exp_q.push_back((seq[i] >> 1) - 1);
            @(posedge clk_in);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ($isunknown(clk_out) || dut.cnt > e) begin
                errors++;
                $display("FAIL rapid_seq idx=%0d actual_out=%0b actual_cnt=%0d required_cnt_max=%0d",
                         i, clk_out, dut.cnt, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_period(37, 6);
        test_period(200, 6);
        test_period(4, 6);
        test_period(5, 6);
        test_silence(0);
        test_silence(1);
        test_async_reset();
        test_grow();
        test_shrink();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
